// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg
// Shared definitions for the BRAM port arbiter slice.
//   arb_state_t        : top-level sequencer states (ARB = serve requesters,
//                        CLEAR = sweep the whole memory with CLEAR_VALUE)
//   RD_LATENCY_DEFAULT : read latency of the BRAM in HIGH_PERFORMANCE mode
//   TAG_DEPTH          : depth of the read-tag pipeline at the default latency
//                        (one issue-register stage plus the BRAM latency)
package bram_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    localparam int RD_LATENCY_DEFAULT = 2;
    localparam int TAG_DEPTH          = 1 + RD_LATENCY_DEFAULT;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter: combinational one-hot grant from a request vector and
// an internal pointer, with the pointer updated on the clock after a grant.
// Optional build macro: BRAM_ARB_PRIO0_EN (requester 0 has absolute priority,
// the others rotate among themselves).
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset, pointer returns to 0
//   enable in  when 0 no grant is produced and the pointer holds
//   req    in  NUM_REQ request bits
//   grant  out NUM_REQ one-hot grant, or zero
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] cand;
    logic               found;

    // Candidate set. With the priority option, a valid requester 0 masks
    // everyone else; otherwise bit 0 is already clear and the rotating search
    // only ever lands on requesters 1..NUM_REQ-1.
    always_comb begin
        cand = req;
`ifdef BRAM_ARB_PRIO0_EN
        if (req[0]) begin
            cand = {{(NUM_REQ-1){1'b0}}, 1'b1};
        end
`endif
        if (!enable) begin
            cand = '0;
        end
    end

    // First candidate at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && cand[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                gnt_idx    = PTR_W'(idx);
            end
        end
    end

    // Pointer moves just past the winner; with the priority option a grant to
    // requester 0 leaves the rotation of the others untouched.
    always_comb begin
        ptr_next = ptr;
        if (found) begin
`ifdef BRAM_ARB_PRIO0_EN
            if (gnt_idx != '0) begin
                ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
            end
`else
            ptr_next = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one port of a read-first BRAM between NUM_REQ requesters with
// round-robin arbitration, routes read data back to the requester that issued
// the read (one-hot tag pipeline), and can sweep the whole memory with
// CLEAR_VALUE (frame / depth buffer clear).
// Optional build macro: BRAM_ARB_PRIO0_EN (requester 0 has absolute priority).
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   req_valid_in/we/addr/data  per-requester request, packed slice i = req i
//   req_ready_out         one-hot grant (transfer = valid & ready)
//   rsp_valid_out         one-hot read-data valid, 1+RD_LATENCY after handshake
//   rsp_data_out          read data shared by all requesters
//   clear_start_in        starts a clear sweep from ARB
//   clear_busy_out        high while sweeping
//   clear_done_out        pulse in the cycle the last clear write is issued
//   bram_*_out / bram_dout_in  BRAM port A (addra, dina, wea, ena, regcea, douta)
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 18,
    parameter int                    RAM_DEPTH   = 1024,
    parameter int                    RD_LATENCY  = RD_LATENCY_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ-1:0]             req_we_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_in,
    output logic [NUM_REQ-1:0]             req_ready_out,
    output logic [NUM_REQ-1:0]             rsp_valid_out,
    output logic [DATA_WIDTH-1:0]          rsp_data_out,
    input  logic                           clear_start_in,
    output logic                           clear_busy_out,
    output logic                           clear_done_out,
    output logic [ADDR_WIDTH-1:0]          bram_addr_out,
    output logic [DATA_WIDTH-1:0]          bram_din_out,
    output logic                           bram_we_out,
    output logic                           bram_en_out,
    output logic                           bram_regce_out,
    input  logic [DATA_WIDTH-1:0]          bram_dout_in
);

    // TAG_DEPTH is sized for the default latency; rebase it when RD_LATENCY
    // is overridden so the tag always lines up with douta.
    localparam int                    TAG_LEN   = TAG_DEPTH - RD_LATENCY_DEFAULT + RD_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic                    clear_last;
    logic                    arb_enable;
    logic [NUM_REQ-1:0]      grant;
    logic                    transfer;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_REQ-1:0]      tag_pipe [TAG_LEN];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk    (clk_in),
        .rst    (rst_in),
        .enable (arb_enable),
        .req    (req_valid_in),
        .grant  (grant)
    );

    // Grants only ever go to valid requesters, so any grant is a transfer.
    assign transfer       = |grant;
    assign req_ready_out  = grant;
    assign clear_busy_out = (state == CLEAR);
    assign clear_done_out = clear_last;
    assign bram_regce_out = 1'b1;

    // Sequencer: clear_start_in wins over arbitration in ARB (no grant that
    // cycle); CLEAR leaves in the cycle the final address is issued.
    always_comb begin
        state_next = state;
        arb_enable = 1'b0;
        clear_last = 1'b0;
        case (state)
            ARB: begin
                if (clear_start_in) begin
                    state_next = CLEAR;
                end else begin
                    arb_enable = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    clear_last = 1'b1;
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // The clear address is parked at 0 in ARB so every sweep starts from 0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ARB;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + ADDR_WIDTH'(1);
            end else begin
                clr_addr <= '0;
            end
        end
    end

    // Select the granted requester's slice of the packed request buses.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_we   = req_we_in[i];
                sel_addr = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // BRAM issue register: clear writes, then granted accesses, otherwise the
    // port is disabled. Address/data hold their last value when idle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bram_en_out   <= 1'b0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_din_out  <= '0;
        end else if (state == CLEAR) begin
            bram_en_out   <= 1'b1;
            bram_we_out   <= 1'b1;
            bram_addr_out <= clr_addr;
            bram_din_out  <= CLEAR_VALUE;
        end else if (transfer) begin
            bram_en_out   <= 1'b1;
            bram_we_out   <= sel_we;
            bram_addr_out <= sel_addr;
            bram_din_out  <= sel_data;
        end else begin
            bram_en_out   <= 1'b0;
            bram_we_out   <= 1'b0;
        end
    end

    // Read tags: the one-hot grant of each read travels alongside the access
    // so it emerges exactly when douta carries that read's data. Reset flushes
    // it, which drops any read still in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < TAG_LEN; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= (transfer && !sel_we) ? grant : '0;
            for (int i = 1; i < TAG_LEN; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rsp_valid_out = tag_pipe[TAG_LEN-1];
    assign rsp_data_out  = (|rsp_valid_out) ? bram_dout_in : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a behavioural read-first BRAM
// (2-cycle latency, regce always on). Table-driven arbitration/response
// vectors plus hand sequences for clear and mid-operation reset.
module tb_bram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_we;
    logic [39:0] req_addr;
    logic [71:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [17:0] rsp_data;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic [9:0]  bram_addr;
    logic [17:0] bram_din;
    logic        bram_we;
    logic        bram_en;
    logic        bram_regce;
    logic [17:0] bram_dout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [17:0] exp_data;
    } vec_t;

    vec_t        tbl [16];
    int          tbl_len;
    logic [9:0]  addr_v [4];
    logic [17:0] data_v [4];

    bram_port_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_we_in      (req_we),
        .req_addr_in    (req_addr),
        .req_data_in    (req_data),
        .req_ready_out  (req_ready),
        .rsp_valid_out  (rsp_valid),
        .rsp_data_out   (rsp_data),
        .clear_start_in (clear_start),
        .clear_busy_out (clear_busy),
        .clear_done_out (clear_done),
        .bram_addr_out  (bram_addr),
        .bram_din_out   (bram_din),
        .bram_we_out    (bram_we),
        .bram_en_out    (bram_en),
        .bram_regce_out (bram_regce),
        .bram_dout_in   (bram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-first BRAM model, two register stages on the read path.
    logic [17:0] mem [1024];
    logic [17:0] rd_q      = '0;
    logic        preloaded = 1'b0;

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= '0;
            end
            mem[0]    <= 18'h00001;
            mem[5]    <= 18'h0002A;
            mem[1023] <= 18'h003FF;
            for (int i = 0; i < 4; i++) begin
                mem[16+i] <= 18'h00100 + 18'(i);
            end
            preloaded <= 1'b1;
        end else if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_din;
            end
            rd_q <= mem[bram_addr];
        end
        bram_dout <= rd_q;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_valid = v.valid;
        req_we    = v.we;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*10 +: 10] = addr_v[i];
            req_data[i*18 +: 18] = data_v[i];
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ready"},  32'(req_ready),  32'h0);
        checkOutput({tag, " rsp"},    32'(rsp_valid),  32'h0);
        checkOutput({tag, " rdata"},  32'(rsp_data),   32'h0);
        checkOutput({tag, " busy"},   32'(clear_busy), 32'h0);
        checkOutput({tag, " done"},   32'(clear_done), 32'h0);
        checkOutput({tag, " en"},     32'(bram_en),    32'h0);
        checkOutput({tag, " we"},     32'(bram_we),    32'h0);
        checkOutput({tag, " addr"},   32'(bram_addr),  32'h0);
        checkOutput({tag, " din"},    32'(bram_din),   32'h0);
        checkOutput({tag, " regce"},  32'(bram_regce), 32'h1);
    endtask

    task automatic doReset();
        req_valid   = '0;
        req_we      = '0;
        clear_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic runTable(input string tag);
        for (int r = 0; r < tbl_len; r++) begin
            @(posedge clk); #1;
            applyStimulus(tbl[r]);
            @(negedge clk);
            checkOutput($sformatf("%s ready row%0d", tag, r), 32'(req_ready), 32'(tbl[r].exp_ready));
            checkOutput($sformatf("%s rsp row%0d", tag, r), 32'(rsp_valid), 32'(tbl[r].exp_rsp));
            if (tbl[r].exp_rsp != '0) begin
                checkOutput($sformatf("%s rdata row%0d", tag, r), 32'(rsp_data), 32'(tbl[r].exp_data));
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_we    = '0;
    endtask

    initial begin
        vec_t v;
        int   busy_cnt;
        int   done_cnt;
        int   done_at;
        int   ready_viol;
        int   cyc;
        int   seen;
        int   seen2;

        rst         = 1'b1;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_v[i] = '0;
            data_v[i] = '0;
        end

        // Single read by requester 0, data back three cycles later.
        doReset();
        addr_v[0] = 10'd5;
        v = '{valid: 4'b0001, we: 4'b0000, exp_ready: 4'b0, exp_rsp: 4'b0, exp_data: 18'h0};
        @(posedge clk); #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t1 grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checkOutput("t1 bram_en", 32'(bram_en), 32'h1);
        checkOutput("t1 bram_we", 32'(bram_we), 32'h0);
        checkOutput("t1 bram_addr", 32'(bram_addr), 32'd5);
        checkOutput("t1 rsp +1", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1 rsp +2", 32'(rsp_valid), 32'h0);
        checkOutput("t1 bram_en idle", 32'(bram_en), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1 rsp +3", 32'(rsp_valid), 32'h1);
        checkOutput("t1 rdata", 32'(rsp_data), 32'h2A);

        // All four requesters reading for 8 cycles.
        doReset();
        for (int i = 0; i < 4; i++) begin
            addr_v[i] = 10'(16 + i);
        end
        tbl_len = 11;
        for (int r = 0; r < 11; r++) begin
            tbl[r].valid     = (r < 8) ? 4'b1111 : 4'b0000;
            tbl[r].we        = 4'b0000;
            tbl[r].exp_ready = (r < 8) ? 4'(1 << (r % 4)) : 4'b0000;
            tbl[r].exp_rsp   = (r >= 3) ? 4'(1 << ((r - 3) % 4)) : 4'b0000;
            tbl[r].exp_data  = (r >= 3) ? 18'h00100 + 18'((r - 3) % 4) : 18'h0;
        end
        runTable("t2");

        // Write by R1 then read-back by R2 in the next cycle.
        addr_v[1] = 10'd7;
        data_v[1] = 18'h00155;
        addr_v[2] = 10'd7;
        tbl_len = 5;
        tbl[0] = '{valid: 4'b0010, we: 4'b0010, exp_ready: 4'b0010, exp_rsp: 4'b0000, exp_data: 18'h0};
        tbl[1] = '{valid: 4'b0100, we: 4'b0000, exp_ready: 4'b0100, exp_rsp: 4'b0000, exp_data: 18'h0};
        tbl[2] = '{valid: 4'b0000, we: 4'b0000, exp_ready: 4'b0000, exp_rsp: 4'b0000, exp_data: 18'h0};
        tbl[3] = '{valid: 4'b0000, we: 4'b0000, exp_ready: 4'b0000, exp_rsp: 4'b0000, exp_data: 18'h0};
        tbl[4] = '{valid: 4'b0000, we: 4'b0000, exp_ready: 4'b0000, exp_rsp: 4'b0100, exp_data: 18'h00155};
        runTable("t3");

        // Clear sweep with R3 waiting.
        addr_v[3] = 10'd19;
        v = '{valid: 4'b1000, we: 4'b0000, exp_ready: 4'b0, exp_rsp: 4'b0, exp_data: 18'h0};
        @(posedge clk); #1;
        applyStimulus(v);
        clear_start = 1'b1;
        @(negedge clk);
        checkOutput("t4 no grant on start", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        clear_start = 1'b0;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_at    = 0;
        ready_viol = 0;
        cyc        = 0;
        while (cyc < 2000) begin
            @(negedge clk);
            if (!clear_busy) begin
                break;
            end
            busy_cnt++;
            if (req_ready != '0) begin
                ready_viol++;
            end
            if (clear_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            @(posedge clk); #1;
            clear_start = (busy_cnt == 500);
            cyc++;
        end
        clear_start = 1'b0;
        checkOutput("t4 busy cycles", 32'(busy_cnt), 32'd1024);
        checkOutput("t4 done pulses", 32'(done_cnt), 32'd1);
        checkOutput("t4 done position", 32'(done_at), 32'd1024);
        checkOutput("t4 ready while busy", 32'(ready_viol), 32'd0);
        checkOutput("t4 R3 grant after clear", 32'(req_ready), 32'h8);
        checkOutput("t4 no done after clear", 32'(clear_done), 32'h0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t4 R3 rsp", 32'(rsp_valid), 32'h8);
        checkOutput("t4 R3 rdata", 32'(rsp_data), 32'h0);
        seen = 0;
        for (int a = 0; a < 1024; a++) begin
            if (mem[a] != '0) begin
                seen++;
            end
        end
        checkOutput("t4 nonzero words", 32'(seen), 32'd0);

        // Reset two cycles after a read handshake drops the response.
        addr_v[0] = 10'd5;
        v = '{valid: 4'b0001, we: 4'b0000, exp_ready: 4'b0, exp_rsp: 4'b0, exp_data: 18'h0};
        @(posedge clk); #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t5 grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkResetOutputs("t5 in reset");
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                seen++;
            end
        end
        checkOutput("t5 dropped rsp", 32'(seen), 32'd0);

        // Reset in the middle of a clear aborts it silently.
        @(posedge clk); #1;
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        @(negedge clk);
        checkOutput("t5 clear busy", 32'(clear_busy), 32'h1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5 abort busy", 32'(clear_busy), 32'h0);
        rst = 1'b0;
        seen  = 0;
        seen2 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (clear_done) begin
                seen++;
            end
            if (clear_busy) begin
                seen2++;
            end
        end
        checkOutput("t5 abort no done", 32'(seen), 32'd0);
        checkOutput("t5 abort stays idle", 32'(seen2), 32'd0);

        // R0 contending with R1/R2, then R0 drops out.
        doReset();
        for (int i = 0; i < 4; i++) begin
            addr_v[i] = 10'(100 + i);
            data_v[i] = 18'(i);
        end
        tbl_len = 8;
        for (int r = 0; r < 8; r++) begin
            tbl[r].valid   = (r < 4) ? 4'b0111 : 4'b0110;
            tbl[r].we      = tbl[r].valid;
            tbl[r].exp_rsp = 4'b0000;
            tbl[r].exp_data = 18'h0;
        end
`ifdef BRAM_ARB_PRIO0_EN
        tbl[0].exp_ready = 4'b0001;
        tbl[1].exp_ready = 4'b0001;
        tbl[2].exp_ready = 4'b0001;
        tbl[3].exp_ready = 4'b0001;
`else
        tbl[0].exp_ready = 4'b0001;
        tbl[1].exp_ready = 4'b0010;
        tbl[2].exp_ready = 4'b0100;
        tbl[3].exp_ready = 4'b0001;
`endif
        tbl[4].exp_ready = 4'b0010;
        tbl[5].exp_ready = 4'b0100;
        tbl[6].exp_ready = 4'b0010;
        tbl[7].exp_ready = 4'b0100;
        runTable("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
